xpb_reduction_sequencer: RTL and testbench

//  Steps one xpb lookup-table bank through the 5-bit digits of a captured

---
 rtl/xpb_reduction_sequencer_if.sv | 31 +++
 rtl/xpb_reduction_sequencer.sv | 98 +++++++++
 tb/tb_xpb_reduction_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/xpb_reduction_sequencer_if.sv
// Handshake and table-bank bus for the xpb reduction sequencer.
// The slave side is the sequencer. The master side is the requester, the table bank and the result consumer.
interface xpb_reduction_sequencer_if #(
  parameter int unsigned WIDTH      = 1024,
  parameter int unsigned DIGIT_BITS = 5,
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned ACC_GUARD  = 8
);
  localparam int unsigned SEL_BITS = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                             start_valid;
  logic                             start_ready;
  logic [NUM_DIGITS*DIGIT_BITS-1:0] digits_in;
  logic [SEL_BITS-1:0]              lut_sel;
  logic [DIGIT_BITS-1:0]            lut_digit;
  logic [WIDTH-1:0]                 lut_data;
  logic                             busy;
  logic [WIDTH+ACC_GUARD-1:0]       result;
  logic                             result_valid;
  logic                             result_ready;

  modport slave (
    input  start_valid, digits_in, lut_data, result_ready,
    output start_ready, lut_sel, lut_digit, busy, result, result_valid
  );

  modport master (
    output start_valid, digits_in, lut_data, result_ready,
    input  start_ready, lut_sel, lut_digit, busy, result, result_valid
  );
endinterface

// File: rtl/xpb_reduction_sequencer.sv
// Walks one xpb table bank through the captured digits, one digit per cycle.
// It sums the returned constants into a guarded accumulator that never wraps.
module xpb_reduction_sequencer #(
  parameter int unsigned WIDTH      = 1024,
  parameter int unsigned DIGIT_BITS = 5,
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned ACC_GUARD  = 8
) (
  input logic                      clk,
  input logic                      reset,
  xpb_reduction_sequencer_if.slave bus
);
  localparam int unsigned SEL_BITS = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned ACC_W    = WIDTH + ACC_GUARD;
  localparam logic [SEL_BITS-1:0] LAST = SEL_BITS'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [SEL_BITS-1:0]   cnt;
  logic [SEL_BITS-1:0]   nxt;
  logic [DIGIT_BITS-1:0] shadow [NUM_DIGITS];
  logic [DIGIT_BITS-1:0] digit_q;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      term;
  logic [ACC_W-1:0]      sum;
  logic [ACC_W-1:0]      result_q;
  logic                  busy_q;
  logic                  valid_q;
  logic                  ready_q;

  // A zero digit adds nothing, whatever the table returns for index 0.
  always_comb begin
    term = '0;
    if (digit_q != '0) term = ACC_W'(bus.lut_data);
    sum = acc + term;
    nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      digit_q  <= '0;
      acc      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) shadow[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++)
              shadow[i] <= bus.digits_in[i*DIGIT_BITS +: DIGIT_BITS];
            digit_q <= bus.digits_in[DIGIT_BITS-1:0];
            cnt     <= '0;
            acc     <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          acc <= sum;
          // The counter and digit wrap to 0 on the last step, so the table inputs stay idle outside RUN.
          if (cnt == LAST) begin
            result_q <= sum;
            cnt      <= '0;
            digit_q  <= '0;
            valid_q  <= 1'b1;
            state    <= DONE;
          end else begin
            cnt     <= nxt;
            digit_q <= shadow[nxt];
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.start_ready  = ready_q;
  assign bus.lut_sel      = cnt;
  assign bus.lut_digit    = digit_q;
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
endmodule

// File: tb/tb_xpb_reduction_sequencer.sv
// Directed bench for xpb_reduction_sequencer with four digits and a stub table bank.
// A job-level reference model is checked every cycle, and literal expectations pin the model.
module tb_xpb_reduction_sequencer;
  localparam int unsigned W     = 1024;
  localparam int unsigned DB    = 5;
  localparam int unsigned ND    = 4;
  localparam int unsigned AG    = 8;
  localparam int unsigned ACC_W = W + AG;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned tbl_mode = 0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  xpb_reduction_sequencer_if #(.WIDTH(W), .DIGIT_BITS(DB), .NUM_DIGITS(ND), .ACC_GUARD(AG)) bus ();

  xpb_reduction_sequencer #(.WIDTH(W), .DIGIT_BITS(DB), .NUM_DIGITS(ND), .ACC_GUARD(AG)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Table modes: 0 = (sel+1)*digit, 1 = all ones for nonzero digits, 2 = (sel+1)*digit+100.
  function automatic logic [W-1:0] tbl(int unsigned sel, int unsigned dig, int unsigned mode);
    logic [W-1:0] v;
    v = '0;
    if (mode == 1) begin
      if (dig != 0) v = '1;
    end else if (mode == 2) begin
      v = W'((sel + 1) * dig + 100);
    end else begin
      v = W'((sel + 1) * dig);
    end
    return v;
  endfunction

  function automatic logic [ACC_W-1:0] job_sum(logic [ND*DB-1:0] d, int unsigned mode);
    logic [ACC_W-1:0] s;
    int unsigned dg;
    s = '0;
    for (int k = 0; k < ND; k++) begin
      dg = int'(d[k*DB +: DB]);
      if (dg != 0) s = s + ACC_W'(tbl(k, dg, mode));
    end
    return s;
  endfunction

  always_comb bus.lut_data = tbl(bus.lut_sel, bus.lut_digit, tbl_mode);

  task automatic chk(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h..%h expected %h..%h", name, act[ACC_W-1:992], act[63:0],
               exp[ACC_W-1:992], exp[63:0]);
    end
  endtask

  // Reference model: a job occupies ND edges after acceptance, then it waits for result_ready.
  bit               m_in_job;
  int               m_k;
  logic [DB-1:0]    m_dig [ND];
  logic [ACC_W-1:0] m_res;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_in_job <= 1'b0;
      m_k      <= 0;
    end else if (!m_in_job) begin
      if (bus.start_valid) begin
        m_in_job <= 1'b1;
        m_k      <= 0;
        for (int k = 0; k < ND; k++) m_dig[k] <= bus.digits_in[k*DB +: DB];
        m_res    <= job_sum(bus.digits_in, tbl_mode);
      end
    end else if (m_k < ND) begin
      m_k <= m_k + 1;
    end else if (bus.result_ready) begin
      m_in_job <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("start_ready", ACC_W'(bus.start_ready), ACC_W'(!m_in_job));
      chk("busy", ACC_W'(bus.busy), ACC_W'(m_in_job));
      chk("result_valid", ACC_W'(bus.result_valid), ACC_W'(m_in_job && m_k == ND));
      chk("lut_sel", ACC_W'(bus.lut_sel), (m_in_job && m_k < ND) ? ACC_W'(m_k) : '0);
      chk("lut_digit", ACC_W'(bus.lut_digit), (m_in_job && m_k < ND) ? ACC_W'(m_dig[m_k]) : '0);
      if (m_in_job && m_k == ND) chk("result", bus.result, m_res);
    end
  end

  task automatic start_job(input logic [ND*DB-1:0] d, input int unsigned mode);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    tbl_mode = mode;
    bus.digits_in = d;
    bus.start_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.start_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("start_timeout", 1, 0);
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    bus.digits_in = 20'hABCDE;
  endtask

  task automatic wait_result(output logic [ACC_W-1:0] r, output int n);
    n = 0;
    while (!bus.result_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.result_valid) chk("result_timeout", 1, 0);
    r = bus.result;
  endtask

  task automatic release_result();
    @(negedge clk);
    bus.result_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.result_ready = 1'b0;
    chk("release_start_ready", ACC_W'(bus.start_ready), 1);
    chk("release_valid", ACC_W'(bus.result_valid), 0);
  endtask

  logic [ACC_W-1:0] r;
  logic [ACC_W-1:0] big;
  int n;
  int c1;
  int c2;

  initial begin
    bus.start_valid = 1'b0;
    bus.digits_in = '0;
    bus.result_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_result", bus.result, 0);
    chk("reset_valid", ACC_W'(bus.result_valid), 0);
    chk("reset_busy", ACC_W'(bus.busy), 0);
    chk("reset_sel", ACC_W'(bus.lut_sel), 0);
    reset = 1'b0;

    // Scenario 1: all-zero digits, fixed latency.
    start_job({5'd0, 5'd0, 5'd0, 5'd0}, 0);
    wait_result(r, n);
    chk("s1_result", r, 0);
    chk("s1_latency_edges", ACC_W'(n), 5);
    release_result();

    // Scenario 2: digits 1..4 step through the bank.
    start_job({5'd4, 5'd3, 5'd2, 5'd1}, 0);
    for (int k = 0; k < ND; k++) begin
      @(negedge clk);
      chk("s2_sel_step", ACC_W'(bus.lut_sel), ACC_W'(k));
      chk("s2_digit_step", ACC_W'(bus.lut_digit), ACC_W'(k + 1));
    end
    wait_result(r, n);
    chk("s2_result", r, 30);

    // Scenario 4: a stalled consumer holds DONE, and a start pulse is ignored.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.start_valid = (i == 4);
      bus.digits_in = {5'd31, 5'd31, 5'd31, 5'd31};
    end
    @(negedge clk);
    bus.start_valid = 1'b0;
    chk("s4_valid_held", ACC_W'(bus.result_valid), 1);
    chk("s4_result_held", bus.result, 30);
    chk("s4_start_ready", ACC_W'(bus.start_ready), 0);
    release_result();

    // Scenario 3: saturated table, the guard bits take the carry.
    start_job({5'd31, 5'd31, 5'd31, 5'd31}, 1);
    wait_result(r, n);
    big = '0;
    big[W+2] = 1'b1;
    big = big - 4;
    chk("s3_result", r, big);
    chk("s3_guard_bits", ACC_W'(r[ACC_W-1:W]), 3);
    release_result();

    // Zero digits must ignore a nonzero table output.
    start_job({5'd4, 5'd0, 5'd2, 5'd0}, 2);
    wait_result(r, n);
    chk("zero_digit_gated", r, 220);
    release_result();

    // Scenario 5: async reset during RUN cycle 2.
    start_job({5'd4, 5'd3, 5'd2, 5'd1}, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("s5_sel", ACC_W'(bus.lut_sel), 0);
    chk("s5_busy", ACC_W'(bus.busy), 0);
    chk("s5_result", bus.result, 0);
    chk("s5_valid", ACC_W'(bus.result_valid), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("s5_no_completion", ACC_W'(bus.result_valid), 0);
    start_job({5'd4, 5'd3, 5'd2, 5'd1}, 0);
    wait_result(r, n);
    chk("s5_rerun_result", r, 30);
    release_result();

    // Scenario 6: back-to-back jobs with both handshakes held high.
    @(negedge clk);
    tbl_mode = 0;
    bus.result_ready = 1'b1;
    bus.digits_in = {5'd4, 5'd3, 5'd2, 5'd1};
    bus.start_valid = 1'b1;
    for (int i = 0; i < 50 && !bus.start_ready; i++) @(negedge clk);
    @(posedge clk);
    c1 = cyc;
    #1;
    bus.digits_in = {5'd31, 5'd31, 5'd31, 5'd31};
    wait_result(r, n);
    chk("s6_first", r, 30);
    for (int i = 0; i < 50 && !bus.start_ready; i++) @(negedge clk);
    @(posedge clk);
    c2 = cyc;
    #1;
    bus.start_valid = 1'b0;
    chk("s6_spacing", ACC_W'(c2 - c1), 6);
    wait_result(r, n);
    chk("s6_second", r, 310);
    repeat (4) @(negedge clk);
    bus.result_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
